// File: rtl/tinyalu_param.sv
// tinyalu_param: parametrised multi-mode ALU with start/busy/done handshake.
// Single-cycle add/AND/XOR/subtract; multiply completes after MULT_LATENCY cycles.
module tinyalu_param #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned MULT_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           op,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned CW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic [CW-1:0] MUL_CNT = CW'(MULT_LATENCY - 1);

  logic [1:0]           state;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [2:0]           op_r;
  logic [CW-1:0]        cnt;
  logic                 op_legal;
  logic                 accept;
  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   b_ext;
  logic [2*WIDTH-1:0]   exec_res;

  assign op_legal = (op != 3'b000) && (op <= OP_SUB);
  // Accepting in DONE as well as IDLE gives back-to-back issue without a bubble.
  assign accept   = start && op_legal && ((state == IDLE) || (state == DONE));
  assign busy     = (state == EXEC);
  assign done     = (state == DONE);

  assign a_ext = {{WIDTH{1'b0}}, a_r};
  assign b_ext = {{WIDTH{1'b0}}, b_r};

  always_comb begin
    exec_res = '0;
    case (op_r)
      OP_ADD:  exec_res = a_ext + b_ext;
      OP_AND:  exec_res = a_ext & b_ext;
      OP_XOR:  exec_res = a_ext ^ b_ext;
      OP_MUL:  exec_res = a_ext * b_ext;
      OP_SUB:  exec_res = a_ext - b_ext;
      default: exec_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_r   <= A;
            b_r   <= B;
            op_r  <= op;
            cnt   <= (op == OP_MUL) ? MUL_CNT : '0;
            state <= EXEC;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            result <= exec_res;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_param.sv
// Directed bench for tinyalu_param (WIDTH=8, MULT_LATENCY=3) with a result scoreboard.
module tb_tinyalu_param;

  logic        clk;
  logic        reset_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_q[$];
  logic        prev_done = 1'b0;

  tinyalu_param #(.WIDTH(8), .MULT_LATENCY(3)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op),
    .start(start), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    op = o; A = a; B = b; start = 1'b1;
  endtask

  // Scoreboard: every done pops one expected result; done never repeats.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_done: observed done=1 result=%0h expected no pending op", result);
      end
      if (exp_q.size() > 0) chk("sb_result", result, exp_q.pop_front());
      checks++;
      assert (prev_done === 1'b0) else begin
        errors++;
        $error("FAIL done_twice: observed done in consecutive cycles expected single pulse");
      end
    end
    prev_done = done;
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 3'b000; A = '0; B = '0;
    cyc(); cyc();
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_result", result, 16'h0000);
    reset_n = 1'b1;
    cyc();

    // Add with carry
    issue(3'b001, 8'hFF, 8'hFF); exp_q.push_back(16'h01FE);
    cyc(); start = 1'b0;
    chk("add_busy", 16'(busy), 16'd1);
    chk("add_nodone", 16'(done), 16'd0);
    cyc();
    chk("add_busy_low", 16'(busy), 16'd0);
    chk("add_done", 16'(done), 16'd1);
    cyc();
    chk("add_done_low", 16'(done), 16'd0);
    chk("add_hold", result, 16'h01FE);

    // Multiply with operand change during EXEC
    issue(3'b100, 8'hFF, 8'hFF); exp_q.push_back(16'hFE01);
    cyc(); start = 1'b0; A = 8'h00; B = 8'h00;
    chk("mul_busy1", 16'(busy), 16'd1);
    cyc(); chk("mul_busy2", 16'(busy), 16'd1);
    cyc(); chk("mul_busy3", 16'(busy), 16'd1);
    chk("mul_nodone", 16'(done), 16'd0);
    cyc();
    chk("mul_busy_low", 16'(busy), 16'd0);
    chk("mul_done", 16'(done), 16'd1);
    chk("mul_result", result, 16'hFE01);
    cyc(); chk("mul_hold", result, 16'hFE01);

    // Subtract wrap, then AND issued in the done cycle
    issue(3'b101, 8'h00, 8'h01); exp_q.push_back(16'hFFFF);
    cyc(); start = 1'b0;
    cyc();
    chk("sub_done", 16'(done), 16'd1);
    chk("sub_result", result, 16'hFFFF);
    issue(3'b010, 8'hF0, 8'h3C); exp_q.push_back(16'h0030);
    cyc(); start = 1'b0;
    chk("b2b_busy", 16'(busy), 16'd1);
    chk("b2b_nodone", 16'(done), 16'd0);
    cyc();
    chk("and_done", 16'(done), 16'd1);
    chk("and_result", result, 16'h0030);
    cyc();

    // Start while busy is dropped
    issue(3'b100, 8'h10, 8'h10); exp_q.push_back(16'h0100);
    cyc();
    issue(3'b001, 8'h01, 8'h01);
    cyc(); start = 1'b0;
    cyc();
    cyc();
    chk("drop_done", 16'(done), 16'd1);
    chk("drop_result", result, 16'h0100);
    cyc();
    chk("drop_no_busy", 16'(busy), 16'd0);
    cyc(); cyc();
    chk("drop_result_hold", result, 16'h0100);

    // Reset in the middle of a multiply
    issue(3'b100, 8'h03, 8'h05);
    cyc(); start = 1'b0;
    cyc(); reset_n = 1'b0;
    cyc();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", result, 16'h0000);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rst_no_done", 16'(done), 16'd0);
    end

    // Known result, then illegal / no-op codes leave it alone
    issue(3'b011, 8'hA5, 8'hFF); exp_q.push_back(16'h005A);
    cyc(); start = 1'b0;
    cyc(); chk("xor_result", result, 16'h005A);
    cyc();
    for (int k = 0; k < 3; k++) begin
      logic [2:0] ops [3];
      ops[0] = 3'b000; ops[1] = 3'b110; ops[2] = 3'b111;
      issue(ops[k], 8'h12, 8'h34);
      for (int i = 0; i < 5; i++) begin
        cyc();
        chk("ill_busy", 16'(busy), 16'd0);
        chk("ill_done", 16'(done), 16'd0);
        chk("ill_result", result, 16'h005A);
      end
    end
    start = 1'b0;
    cyc();

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinyalu_param.md
# tinyalu_param

Parametrised multi-mode ALU for the tinyalu family. It supports WIDTH-bit operands and a 2·WIDTH-bit result. Add, AND, XOR and subtract complete in one cycle; multiply is multi-cycle with configurable latency. A start/busy/done handshake sits between the bus-side driver and the result consumer. Operands are captured at acceptance, so the driver may change A/B while an operation runs.

## Interface
- WIDTH, 8: operand width in bits; result is 2·WIDTH. Legal range ≥ 2.
- MULT_LATENCY, 3: cycles from accept edge to done for multiply. Legal range ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  reset is synchronous and active-low; sampled on clk rising edge.
- A  input  WIDTH  operand A, captured on the accept edge.
- B  input  WIDTH  operand B, captured on the accept edge.
- op  input  3  opcode, captured on the accept edge.
- start  input  1  request; qualified by op and busy.
- busy  output  1  operation in flight; start is ignored while high.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- result  output  2·WIDTH  registered result; holds until the next completion.

## Operation
Opcodes:
- 000: no-op.
- 001: add. result = zero-extended A + B (carry lands in bit WIDTH).
- 010: AND. result = zero-extended A & B.
- 011: XOR. result = zero-extended A ^ B.
- 100: multiply. result = A × B, unsigned, full 2·WIDTH bits.
- 101: subtract. result = ({WIDTH'0,A} − {WIDTH'0,B}) mod 2^(2·WIDTH). Two's-complement wrap, so a negative difference yields upper bits all ones.
- 110, 111: reserved. Treated exactly like 000.

Accept condition: start=1, busy=0 and op in {001..101}.
- On the accept edge, A, B and op are registered internally.
- start with op 000/110/111 is never accepted: busy, done and result are unchanged.

FSM states:
- IDLE
  - accept → EXEC, with latency counter loaded to LAT−1.
  - LAT = 1 for ops 001/010/011/101; LAT = MULT_LATENCY for op 100.
- EXEC
  - counter ≠ 0: decrement.
  - counter = 0: register result, → DONE.
- DONE
  - done=1 for exactly this cycle.
  - accept → EXEC (back-to-back start allowed in the done cycle).
  - otherwise → IDLE.

Output and reset rules:
- busy = 1 exactly when state = EXEC.
- done = 1 exactly when state = DONE.
- result changes only on the EXEC→DONE edge, or on reset.
- Reset values: state IDLE, busy 0, done 0, result 0, internal operand/op/counter registers 0.
- Synchronous reset wins over every other event on the same edge, including mid-EXEC and in the DONE cycle. An in-flight operation is discarded and no done is produced.
- Multiplier implementation is free: combinational with delay registers, or iterative. Only the cycle behaviour at the ports is specified.

## Timing
- Accept at edge k:
  - busy high from the cycle after edge k up to edge k+LAT.
  - done and the new result are visible in the cycle after edge k+LAT.
- Single-cycle ops: busy high 1 cycle, then done 1 cycle.
- Multiply: busy high for MULT_LATENCY cycles, then done 1 cycle.
  - MULT_LATENCY=1 gives multiply the same timing as the single-cycle ops.
- Back-to-back: a start accepted in the done cycle gives the next done LAT+1 cycles after the previous done. Peak throughput is one op per LAT+1 cycles.
- start asserted while busy=1 is dropped, not queued. A, B and op changes during EXEC have no effect.
- done is never asserted for two consecutive cycles.

## Test plan
All scenarios use WIDTH=8, MULT_LATENCY=3.
- Add carry: A=0xFF, B=0xFF, op=001, start at edge k → busy high 1 cycle; done with result=0x01FE after edge k+1; result holds 0x01FE afterwards.
- Multiply with operand change: A=0xFF, B=0xFF, op=100 at edge k; A/B changed to 0x00 at edge k+1 → busy high 3 cycles; done after edge k+3 with result=0xFE01.
- Subtract wrap, then back-to-back: A=0x00, B=0x01, op=101 → result=0xFFFF. Start AND (0xF0 & 0x3C) in that done cycle → result=0x0030 two cycles later.
- Start while busy: multiply 0x10×0x10 is in flight, then start with op=001 at edge k+1 → single done with result=0x0100; add never executes.
- Reset mid-operation: reset_n=0 sampled at edge k+2 of a multiply → busy=0, done=0, result=0x0000 after that edge; no done afterwards.
- Illegal and no-op codes: start with op=000, 110, 111 → busy and done stay 0 and result keeps its prior value for 5 cycles.
